aes_decrypt_iter: RTL and testbench

- Iterative AES-128 inverse cipher (FIPS-197 InvCipher); the decrypt-direction counterpart of the forward round datapath.
- Processes one 128-bit ciphertext block at one round per clock.
- Fetches round keys through an index/data port from an external key store, and uses valid/ready handshakes on input and output.
- Used for ECB/CBC-style decrypt paths beside the CTR engine.

---
 rtl/aes_dec_pkg.sv | 76 +++++++
 rtl/aes_inv_round.sv | 53 +++++
 rtl/aes_decrypt_iter.sv | 129 ++++++++++++
 tb/tb_aes_decrypt_iter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative AES-128 decrypt core.
// The inverse S-box is computed as inverse affine followed by multiplicative inversion.
package aes_dec_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } dec_state_e;

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] m8;
    m8 = gf_mul2(gf_mul2(gf_mul2(a)));
    return m8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    logic [7:0] m2, m8;
    m2 = gf_mul2(a);
    m8 = gf_mul2(gf_mul2(m2));
    return m8 ^ m2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    logic [7:0] m4, m8;
    m4 = gf_mul2(gf_mul2(a));
    m8 = gf_mul2(m4);
    return m8 ^ m4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    logic [7:0] m2, m4, m8;
    m2 = gf_mul2(a);
    m4 = gf_mul2(m2);
    m8 = gf_mul2(m4);
    return m8 ^ m4 ^ m2;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_mul2(sh);
    end
    return acc;
  endfunction

  // a^254 == a^-1 for nonzero a, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc, p;
    acc = 8'h01;
    p   = a;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// skip_mix bypasses InvMixColumns for the last round.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] round_key,
  input  logic                 skip_mix,
  output logic [AES_BLK_W-1:0] state_out
);

  logic [7:0]           sb [16];
  logic [AES_BLK_W-1:0] ark;
  logic [AES_BLK_W-1:0] mixed;

  // Byte i sits at row i%4, column i/4; row r is rotated right by r columns.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = inv_sbox(state_in[127-8*((i%4) + 4*(((i/4) - (i%4) + 4) % 4)) -: 8]);
    end
  end

  always_comb begin
    ark = '0;
    for (int i = 0; i < 16; i++) begin
      ark[127-8*i -: 8] = sb[i] ^ round_key[127-8*i -: 8];
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127-32*c -: 8];
      a1 = ark[119-32*c -: 8];
      a2 = ark[111-32*c -: 8];
      a3 = ark[103-32*c -: 8];
      mixed[127-32*c -: 32] = {
        gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
        gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
        gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
        gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)
      };
    end
  end

  assign state_out = skip_mix ? ark : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched by index.
// Define AES_DEC_ABORT_EN to add the abort input that cancels an in-flight block.
//
// state | meaning
// IDLE  | ready for a ciphertext block, rk10 requested
// ROUND | inverse rounds 9..1, counter selects the round key
// FINAL | last round without InvMixColumns, result latched
// DONE  | plaintext held until out_ready
module aes_decrypt_iter
  import aes_dec_pkg::*;
#(
  parameter int NR        = AES_NR,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_block,
  output logic [KEY_IDX_W-1:0] rk_idx,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_block,
`ifdef AES_DEC_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy
);

  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NR);

  dec_state_e           state_q, state_d;
  logic [KEY_IDX_W-1:0] cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] blk_q, blk_d;
  logic [AES_BLK_W-1:0] out_blk_q, out_blk_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 skip_mix;
  logic [AES_BLK_W-1:0] round_out;

  aes_inv_round u_round (
    .state_in  (blk_q),
    .round_key (rk_data),
    .skip_mix  (skip_mix),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= LAST_IDX;
      blk_q       <= '0;
      out_blk_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      out_blk_q   <= out_blk_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    out_blk_d   = out_blk_q;
    out_valid_d = out_valid_q;
    rk_idx      = LAST_IDX;
    skip_mix    = 1'b0;
    case (state_q)
      IDLE: begin
        rk_idx = LAST_IDX;
        if (in_valid && in_ready_q) begin
          blk_d   = in_block ^ rk_data;
          cnt_d   = LAST_IDX - 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx = cnt_q;
        blk_d  = round_out;
        if (cnt_q == KEY_IDX_W'(1)) begin
          cnt_d   = '0;
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINAL: begin
        rk_idx      = '0;
        skip_mix    = 1'b1;
        out_blk_d   = round_out;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        rk_idx = '0;
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = LAST_IDX;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_DEC_ABORT_EN
    // Abort wins over FINAL so a cancelled block never produces a valid pulse.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      cnt_d       = LAST_IDX;
      blk_d       = blk_q;
      out_blk_d   = out_blk_q;
      out_valid_d = 1'b0;
    end
`endif
  end

  assign in_ready_d = (state_d == IDLE);
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_block  = out_blk_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: table-driven AES inverse-cipher model,
// per-cycle compare of handshakes, key index and plaintext, plus FIPS-197 vectors.
`timescale 1ns/1ps
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         busy;
`ifdef AES_DEC_ABORT_EN
  logic         abort = 1'b0;
`endif

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
`ifdef AES_DEC_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [127:0] rk_store [0:10];
  assign rk_data = (rk_idx <= 4'd10) ? rk_store[rk_idx] : '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int n_expect_done = 0;
  int acc_hist[$];

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // Forward S-box by brute-force inversion plus affine map, then inverted as a table.
  task automatic build_tables();
    logic [7:0] inv, a;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      a = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = a;
      isbox[a] = 8'(x);
    end
  endtask

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_store[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] pt;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk_store[10][127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row+4*col] = isbox[s[row + 4*((col - row + 4) % 4)]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ rk_store[r][127-8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
          s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
          s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
          s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    pt = '0;
    for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = s[i];
    return pt;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: m_active/m_acc describe the block in flight as seen by the model.
  bit           m_active = 1'b0;
  int           m_acc = 0;
  logic [127:0] m_exp = '0;
  bit           skip = 1'b1;

  always @(negedge clk) begin : mon
    int k;
    bit ab;
    ab = 1'b0;
`ifdef AES_DEC_ABORT_EN
    ab = abort;
`endif
    k = cyc - m_acc;
    if (!rst_n) begin
      m_active = 1'b0;
      skip = 1'b1;
    end else if (skip) begin
      skip = 1'b0;
    end else begin
      if (!m_active) begin
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_in_ready", 128'(in_ready), 128'(1));
        chk("idle_rk_idx", 128'(rk_idx), 128'(10));
        chk("idle_out_valid", 128'(out_valid), 128'(0));
      end else begin
        chk("run_busy", 128'(busy), 128'(1));
        chk("run_in_ready", 128'(in_ready), 128'(0));
        chk("run_rk_idx", 128'(rk_idx), 128'((k <= 9) ? 9 - k : 0));
        chk("run_out_valid", 128'(out_valid), 128'(k >= 10));
        if (k >= 10) chk("out_block", out_block, m_exp);
      end
      if (!m_active) begin
        if (in_valid) begin
          m_active = 1'b1;
          m_acc = cyc + 1;
          m_exp = model_dec(in_block);
          acc_hist.push_back(cyc + 1);
        end
      end else if (ab) begin
        m_active = 1'b0;
      end else if (k >= 10 && out_ready) begin
        m_active = 1'b0;
        n_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bound_chk(input string name, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    end
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic run_block(input logic [127:0] ct, input int hold);
    bit ok;
    in_block = ct;
    in_valid = 1'b1;
    wait_accept(ok);
    bound_chk("accept", ok);
    in_valid = 1'b0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    wait_out(ok);
    bound_chk("out_valid", ok);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_expect_done++;
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    bit ok;
    logic [127:0] ct2;
    build_tables();
    key_expand(C1_KEY);

    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_block", out_block, 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(10));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    chk("model_c1_rk10", rk_store[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_c1_pt", model_dec(C1_CT), C1_PT);
    run_block(C1_CT, 0);
    chk("c1_out_block", out_block, C1_PT);

    key_expand(B_KEY);
    chk("model_b_rk10", rk_store[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_b_pt", model_dec(B_CT), B_PT);
    run_block(B_CT, 0);
    chk("b_out_block", out_block, B_PT);

    // Backpressure: hold 20 cycles, then IDLE one edge after out_ready.
    run_block(B_CT, 20);
    chk("bp_in_ready_after", 128'(in_ready), 128'(1));
    chk("bp_busy_after", 128'(busy), 128'(0));

    // Back-to-back with in_valid held and out_ready high.
    key_expand(C1_KEY);
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    in_block = C1_CT;
    in_valid = 1'b1;
    wait_accept(ok);
    bound_chk("b2b_accept1", ok);
    in_block = ct2;
    wait_accept(ok);
    bound_chk("b2b_accept2", ok);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
    bound_chk("b2b_drain", ok);
    out_ready = 1'b0;
    n_expect_done += 2;
    chk("b2b_spacing", 128'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]), 128'(12));

    // Reset mid-block, around round 5.
    in_block = C1_CT;
    in_valid = 1'b1;
    wait_accept(ok);
    bound_chk("rst_mid_accept", ok);
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_in_ready", 128'(in_ready), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid_in_ready_after", 128'(in_ready), 128'(1));
    chk("rst_mid_out_valid_after", 128'(out_valid), 128'(0));
    run_block(C1_CT, 1);
    chk("rst_mid_next_block", out_block, C1_PT);

`ifdef AES_DEC_ABORT_EN
    in_block = C1_CT;
    in_valid = 1'b1;
    wait_accept(ok);
    bound_chk("abort_accept", ok);
    in_valid = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    repeat (15) tick();
    run_block(C1_CT, 0);
    chk("abort_next_block", out_block, C1_PT);
    in_block = C1_CT;
    in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    wait_out(ok);
    bound_chk("abort_done_out", ok);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_out_valid", 128'(out_valid), 128'(0));
    tick();
`endif

    for (int n = 0; n < 24; n++) begin
      key_expand({$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) tick();
      run_block({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));
    end
    repeat (3) tick();
    chk("blocks_completed", 128'(n_done), 128'(n_expect_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
